// File: rtl/fifo_to_mem.sv
// Round-robin drain of four fallthrough FIFOs into per-queue QDR write regions.
// Define FIFO_TO_MEM_WRAP_EN for ring-overwrite at region end; default stops the queue when its region is full.

module fifo_to_mem_queue #(
    parameter int AW = 19
) (
    input  logic          clk,
    input  logic          clear,
    input  logic [AW-1:0] addr_low,
    input  logic [AW-1:0] addr_high,
    input  logic          grant,
    output logic [AW-1:0] ptr,
    output logic [AW:0]   word_count,
    output logic          region_full
);
    localparam logic [AW-1:0] ONE  = 1;
    localparam logic [AW:0]   CONE = 1;

    // Region bounds are captured at clear so mid-run edits cannot corrupt the pointer.
    logic [AW-1:0] low_r, high_r;

    always_ff @(posedge clk) begin
        if (clear) begin
            low_r       <= addr_low;
            high_r      <= addr_high;
            ptr         <= addr_low;
            word_count  <= '0;
            region_full <= (addr_high <= addr_low);
        end else if (grant) begin
            if (word_count != '1)
                word_count <= word_count + CONE;
            if (ptr == high_r - ONE) begin
`ifdef FIFO_TO_MEM_WRAP_EN
                ptr <= low_r;
`else
                region_full <= 1'b1;
`endif
            end else begin
                ptr <= ptr + ONE;
            end
        end
    end
endmodule

module fifo_to_mem #(
    parameter int NUM_QUEUES      = 4,
    parameter int MEM_ADDR_WIDTH  = 19,
    parameter int MEM_DATA_WIDTH  = 36,
    parameter int MEM_BW_WIDTH    = 4,
    parameter int FIFO_DATA_WIDTH = 72
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sw_enable,
    input  logic                       cal_done,
    output logic                       mem_w_n,
    input  logic                       mem_wr_full,
    output logic [MEM_ADDR_WIDTH-1:0]  mem_ad_wr,
    output logic [MEM_DATA_WIDTH-1:0]  mem_dwl,
    output logic [MEM_DATA_WIDTH-1:0]  mem_dwh,
    output logic [MEM_BW_WIDTH-1:0]    mem_bwl_n,
    output logic [MEM_BW_WIDTH-1:0]    mem_bwh_n,
    input  logic [FIFO_DATA_WIDTH-1:0] q0_fifo_dout,
    input  logic                       q0_fifo_empty,
    output logic                       q0_fifo_rd_en,
    input  logic [MEM_ADDR_WIDTH-1:0]  q0_addr_low,
    input  logic [MEM_ADDR_WIDTH-1:0]  q0_addr_high,
    input  logic                       q0_enable,
    output logic                       q0_region_full,
    output logic [MEM_ADDR_WIDTH:0]    q0_word_count,
    input  logic [FIFO_DATA_WIDTH-1:0] q1_fifo_dout,
    input  logic                       q1_fifo_empty,
    output logic                       q1_fifo_rd_en,
    input  logic [MEM_ADDR_WIDTH-1:0]  q1_addr_low,
    input  logic [MEM_ADDR_WIDTH-1:0]  q1_addr_high,
    input  logic                       q1_enable,
    output logic                       q1_region_full,
    output logic [MEM_ADDR_WIDTH:0]    q1_word_count,
    input  logic [FIFO_DATA_WIDTH-1:0] q2_fifo_dout,
    input  logic                       q2_fifo_empty,
    output logic                       q2_fifo_rd_en,
    input  logic [MEM_ADDR_WIDTH-1:0]  q2_addr_low,
    input  logic [MEM_ADDR_WIDTH-1:0]  q2_addr_high,
    input  logic                       q2_enable,
    output logic                       q2_region_full,
    output logic [MEM_ADDR_WIDTH:0]    q2_word_count,
    input  logic [FIFO_DATA_WIDTH-1:0] q3_fifo_dout,
    input  logic                       q3_fifo_empty,
    output logic                       q3_fifo_rd_en,
    input  logic [MEM_ADDR_WIDTH-1:0]  q3_addr_low,
    input  logic [MEM_ADDR_WIDTH-1:0]  q3_addr_high,
    input  logic                       q3_enable,
    output logic                       q3_region_full,
    output logic [MEM_ADDR_WIDTH:0]    q3_word_count
);
    localparam int AW = MEM_ADDR_WIDTH;

    logic [NUM_QUEUES-1:0][FIFO_DATA_WIDTH-1:0] q_dout;
    logic [NUM_QUEUES-1:0][AW-1:0]              q_low, q_high, q_ptr;
    logic [NUM_QUEUES-1:0][AW:0]                q_cnt;
    logic [NUM_QUEUES-1:0]                      q_empty, q_en, q_full, eligible, gnt;

    assign q_dout  = {q3_fifo_dout, q2_fifo_dout, q1_fifo_dout, q0_fifo_dout};
    assign q_low   = {q3_addr_low, q2_addr_low, q1_addr_low, q0_addr_low};
    assign q_high  = {q3_addr_high, q2_addr_high, q1_addr_high, q0_addr_high};
    assign q_empty = {q3_fifo_empty, q2_fifo_empty, q1_fifo_empty, q0_fifo_empty};
    assign q_en    = {q3_enable, q2_enable, q1_enable, q0_enable};

    assign {q3_fifo_rd_en, q2_fifo_rd_en, q1_fifo_rd_en, q0_fifo_rd_en}     = gnt;
    assign {q3_region_full, q2_region_full, q1_region_full, q0_region_full} = q_full;
    assign q0_word_count = q_cnt[0];
    assign q1_word_count = q_cnt[1];
    assign q2_word_count = q_cnt[2];
    assign q3_word_count = q_cnt[3];

    logic       clear, go, found;
    logic [1:0] last_grant, gnt_id, idx;

    assign clear    = rst | ~sw_enable;
    assign eligible = q_en & ~q_empty & ~q_full;
    assign go       = ~rst & cal_done & sw_enable & ~mem_wr_full & (|eligible);

    // Scan starts one past the last winner so every eligible queue is served in turn.
    always_comb begin
        found  = 1'b0;
        gnt_id = last_grant;
        idx    = last_grant;
        gnt    = '0;
        for (int k = 1; k <= NUM_QUEUES; k++) begin
            idx = last_grant + 2'(k);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
        if (go)
            gnt[gnt_id] = 1'b1;
    end

    genvar i;
    generate
        for (i = 0; i < NUM_QUEUES; i++) begin : g_q
            fifo_to_mem_queue #(.AW(AW)) u_q (
                .clk         (clk),
                .clear       (clear),
                .addr_low    (q_low[i]),
                .addr_high   (q_high[i]),
                .grant       (gnt[i]),
                .ptr         (q_ptr[i]),
                .word_count  (q_cnt[i]),
                .region_full (q_full[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clear) begin
            mem_w_n    <= 1'b1;
            mem_ad_wr  <= '0;
            mem_dwl    <= '0;
            mem_dwh    <= '0;
            mem_bwl_n  <= '1;
            mem_bwh_n  <= '1;
            last_grant <= 2'd3;
        end else if (go) begin
            mem_w_n            <= 1'b0;
            mem_ad_wr          <= q_ptr[gnt_id];
            {mem_dwh, mem_dwl} <= q_dout[gnt_id];
            mem_bwl_n          <= '0;
            mem_bwh_n          <= '0;
            last_grant         <= gnt_id;
        end else begin
            mem_w_n   <= 1'b1;
            mem_bwl_n <= '1;
            mem_bwh_n <= '1;
        end
    end
endmodule

// File: tb/tb_fifo_to_mem.sv
// Directed bench for fifo_to_mem: FIFO models per queue, write log sampled on the falling edge.
module tb_fifo_to_mem;
    localparam int AW = 19, DW = 36, BW = 4, FW = 72;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, sw_enable, cal_done, mem_wr_full, mem_w_n;
    logic [AW-1:0] mem_ad_wr;
    logic [DW-1:0] mem_dwl, mem_dwh;
    logic [BW-1:0] mem_bwl_n, mem_bwh_n;
    logic [3:0][FW-1:0] q_dout;
    logic [3:0][AW-1:0] q_low, q_high;
    logic [3:0][AW:0]   q_cnt;
    logic [3:0] q_empty, q_rd_en, q_en, q_full, flush;

    int checks = 0, errors = 0;

    // FIFO models: wr_p owned by the stimulus process, rd_p by the pop process.
    logic [FW-1:0] fmem [4][16];
    logic [7:0] wr_p [4];
    logic [7:0] rd_p [4];

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_f
            assign q_empty[g] = (wr_p[g] == rd_p[g]);
            assign q_dout[g]  = fmem[g][rd_p[g][3:0]];
        end
    endgenerate

    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (flush[i]) rd_p[i] <= wr_p[i];
            else if (q_rd_en[i] && !q_empty[i]) rd_p[i] <= rd_p[i] + 8'd1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wlog_n = 0;
    logic [AW-1:0] wlog_a [256];
    logic [FW-1:0] wlog_d [256];
    logic [7:0]    wlog_b [256];
    int            wlog_c [256];
    always @(negedge clk)
        if (mem_w_n === 1'b0 && wlog_n < 256) begin
            wlog_a[wlog_n] = mem_ad_wr;
            wlog_d[wlog_n] = {mem_dwh, mem_dwl};
            wlog_b[wlog_n] = {mem_bwh_n, mem_bwl_n};
            wlog_c[wlog_n] = cyc;
            wlog_n++;
        end

    fifo_to_mem dut (
        .clk(clk), .rst(rst), .sw_enable(sw_enable), .cal_done(cal_done),
        .mem_w_n(mem_w_n), .mem_wr_full(mem_wr_full), .mem_ad_wr(mem_ad_wr),
        .mem_dwl(mem_dwl), .mem_dwh(mem_dwh), .mem_bwl_n(mem_bwl_n), .mem_bwh_n(mem_bwh_n),
        .q0_fifo_dout(q_dout[0]), .q0_fifo_empty(q_empty[0]), .q0_fifo_rd_en(q_rd_en[0]),
        .q0_addr_low(q_low[0]), .q0_addr_high(q_high[0]), .q0_enable(q_en[0]),
        .q0_region_full(q_full[0]), .q0_word_count(q_cnt[0]),
        .q1_fifo_dout(q_dout[1]), .q1_fifo_empty(q_empty[1]), .q1_fifo_rd_en(q_rd_en[1]),
        .q1_addr_low(q_low[1]), .q1_addr_high(q_high[1]), .q1_enable(q_en[1]),
        .q1_region_full(q_full[1]), .q1_word_count(q_cnt[1]),
        .q2_fifo_dout(q_dout[2]), .q2_fifo_empty(q_empty[2]), .q2_fifo_rd_en(q_rd_en[2]),
        .q2_addr_low(q_low[2]), .q2_addr_high(q_high[2]), .q2_enable(q_en[2]),
        .q2_region_full(q_full[2]), .q2_word_count(q_cnt[2]),
        .q3_fifo_dout(q_dout[3]), .q3_fifo_empty(q_empty[3]), .q3_fifo_rd_en(q_rd_en[3]),
        .q3_addr_low(q_low[3]), .q3_addr_high(q_high[3]), .q3_enable(q_en[3]),
        .q3_region_full(q_full[3]), .q3_word_count(q_cnt[3])
    );

    function automatic logic [FW-1:0] mkw(input int q, input int k);
        mkw = {8'(q), 56'hC0FFEE00000000, 8'(k)};
    endfunction

    task automatic push(input int q, input logic [FW-1:0] d);
        fmem[q][wr_p[q][3:0]] = d;
        wr_p[q] = wr_p[q] + 8'd1;
    endtask

    task automatic do_clear();
        cal_done = 1'b0; q_en = '0; rst = 1'b1; flush = 4'hf;
        @(negedge clk);
        flush = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) wr_p[i] = '0;
        sw_enable = 1'b1; mem_wr_full = 1'b0;
        q_low  = {19'h40, 19'h30, 19'h20, 19'h10};
        q_high = {19'h48, 19'h38, 19'h28, 19'h14};
        do_clear();
        #1;
        checks++; if (mem_w_n !== 1'b1) begin errors++; $display("FAIL reset_w_n: got %b want 1", mem_w_n); end
        checks++; if (mem_ad_wr !== '0) begin errors++; $display("FAIL reset_addr: got %0h want 0", mem_ad_wr); end
        checks++; if ({mem_dwh, mem_dwl} !== '0) begin errors++; $display("FAIL reset_data: got %0h want 0", {mem_dwh, mem_dwl}); end
        checks++; if ({mem_bwh_n, mem_bwl_n} !== 8'hff) begin errors++; $display("FAIL reset_bw: got %0h want ff", {mem_bwh_n, mem_bwl_n}); end
        checks++; if (q_cnt[0] !== '0 || q_full !== 4'b0) begin errors++; $display("FAIL reset_q: cnt %0h full %b want 0 0000", q_cnt[0], q_full); end
        checks++; if (q_rd_en !== 4'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0000", q_rd_en); end
    endtask

    task automatic test_single_queue();
        int base;
        do_clear();
        for (int k = 0; k < 4; k++) push(0, mkw(0, k));
        base = wlog_n;
        q_en = 4'b0001; cal_done = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        checks++; if (wlog_n - base !== 4) begin errors++; $display("FAIL single_nwr: got %0d want 4", wlog_n - base); end
        for (int k = 0; k < 4 && base + k < wlog_n; k++) begin
            checks++;
            if (wlog_a[base+k] !== AW'(32'h10 + k) || wlog_d[base+k] !== mkw(0, k) || wlog_b[base+k] !== 8'h00
                || wlog_c[base+k] !== wlog_c[base] + k) begin
                errors++;
                $display("FAIL single_wr%0d: got a=%0h d=%0h bw=%0h cyc+%0d want a=%0h d=%0h bw=0 cyc+%0d",
                         k, wlog_a[base+k], wlog_d[base+k], wlog_b[base+k], wlog_c[base+k] - wlog_c[base],
                         32'h10 + k, mkw(0, k), k);
            end
        end
        checks++; if (q_cnt[0] !== 20'd4) begin errors++; $display("FAIL single_cnt: got %0d want 4", q_cnt[0]); end
        checks++; if (mem_w_n !== 1'b1 || mem_bwl_n !== 4'hf) begin errors++; $display("FAIL single_idle: w_n %b bwl %0h want 1 f", mem_w_n, mem_bwl_n); end
        cal_done = 1'b0; q_en = '0;
    endtask

    task automatic test_region_end();
        int base, exp_n;
        logic exp_full;
        do_clear();
        for (int k = 0; k < 6; k++) push(0, mkw(0, k));
        base = wlog_n;
        q_en = 4'b0001; cal_done = 1'b1;
        repeat (12) @(negedge clk);
        #1;
`ifdef FIFO_TO_MEM_WRAP_EN
        exp_n = 6; exp_full = 1'b0;
`else
        exp_n = 4; exp_full = 1'b1;
`endif
        checks++; if (wlog_n - base !== exp_n) begin errors++; $display("FAIL region_nwr: got %0d want %0d", wlog_n - base, exp_n); end
        for (int k = 0; k < exp_n && base + k < wlog_n; k++) begin
            checks++;
            if (wlog_a[base+k] !== AW'(32'h10 + (k % 4)) || wlog_d[base+k] !== mkw(0, k)) begin
                errors++;
                $display("FAIL region_wr%0d: got a=%0h d=%0h want a=%0h d=%0h", k, wlog_a[base+k], wlog_d[base+k],
                         32'h10 + (k % 4), mkw(0, k));
            end
        end
        checks++; if (q_full[0] !== exp_full) begin errors++; $display("FAIL region_full: got %b want %b", q_full[0], exp_full); end
        checks++; if (q_cnt[0] !== 20'(exp_n)) begin errors++; $display("FAIL region_cnt: got %0d want %0d", q_cnt[0], exp_n); end
        checks++; if (8'(wr_p[0] - rd_p[0]) !== 8'(6 - exp_n)) begin errors++; $display("FAIL region_left: got %0d want %0d", 8'(wr_p[0] - rd_p[0]), 6 - exp_n); end
        cal_done = 1'b0; q_en = '0;
    endtask

    task automatic test_empty_region();
        int base;
        q_high[1] = 19'h20;
        do_clear();
        push(1, mkw(1, 0)); push(1, mkw(1, 1));
        base = wlog_n;
        q_en = 4'b0010; cal_done = 1'b1;
        #1;
        checks++; if (q_full[1] !== 1'b1 || q_rd_en !== 4'b0) begin errors++; $display("FAIL empty_region: full %b rd_en %b want 1 0000", q_full[1], q_rd_en); end
        repeat (5) @(negedge clk);
        #1;
        checks++; if (wlog_n - base !== 0 || 8'(wr_p[1] - rd_p[1]) !== 8'd2) begin errors++; $display("FAIL empty_nwr: writes %0d left %0d want 0 2", wlog_n - base, 8'(wr_p[1] - rd_p[1])); end
        cal_done = 1'b0; q_en = '0;
        q_high[1] = 19'h28;
    endtask

    task automatic test_round_robin();
        int base, q, j;
        do_clear();
        for (int k = 0; k < 2; k++)
            for (int qq = 0; qq < 4; qq++) push(qq, mkw(qq, k));
        base = wlog_n;
        q_en = 4'hf; cal_done = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++; if ($countones(q_rd_en) !== 1) begin errors++; $display("FAIL rr_onehot%0d: got %b want one bit", c, q_rd_en); end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (wlog_n - base !== 8) begin errors++; $display("FAIL rr_nwr: got %0d want 8", wlog_n - base); end
        for (int k = 0; k < 8 && base + k < wlog_n; k++) begin
            q = k % 4; j = k / 4;
            checks++;
            if (wlog_a[base+k] !== q_low[q] + AW'(j) || wlog_d[base+k] !== mkw(q, j)) begin
                errors++;
                $display("FAIL rr_wr%0d: got a=%0h d=%0h want a=%0h d=%0h", k, wlog_a[base+k], wlog_d[base+k],
                         q_low[q] + AW'(j), mkw(q, j));
            end
        end
        checks++; if (q_cnt[3] !== 20'd2 || q_cnt[1] !== 20'd2) begin errors++; $display("FAIL rr_cnt: q1 %0d q3 %0d want 2 2", q_cnt[1], q_cnt[3]); end
        cal_done = 1'b0; q_en = '0;
    endtask

    task automatic test_wr_full();
        int base;
        do_clear();
        for (int k = 0; k < 4; k++) push(0, mkw(0, k));
        base = wlog_n;
        q_en = 4'b0001; cal_done = 1'b1;
        @(negedge clk);
        mem_wr_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (q_rd_en !== 4'b0) begin errors++; $display("FAIL full_rd_en%0d: got %b want 0000", i, q_rd_en); end
            checks++; if (mem_w_n !== (i > 0)) begin errors++; $display("FAIL full_w_n%0d: got %b want %b", i, mem_w_n, i > 0); end
            @(negedge clk);
        end
        #1;
        checks++; if (mem_w_n !== 1'b1) begin errors++; $display("FAIL full_w_n3: got %b want 1", mem_w_n); end
        mem_wr_full = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        checks++; if (wlog_n - base !== 4) begin errors++; $display("FAIL full_nwr: got %0d want 4", wlog_n - base); end
        for (int k = 0; k < 4 && base + k < wlog_n; k++) begin
            checks++;
            if (wlog_a[base+k] !== AW'(32'h10 + k) || wlog_d[base+k] !== mkw(0, k)) begin
                errors++;
                $display("FAIL full_wr%0d: got a=%0h d=%0h want a=%0h d=%0h", k, wlog_a[base+k], wlog_d[base+k], 32'h10 + k, mkw(0, k));
            end
        end
        cal_done = 1'b0; q_en = '0;
    endtask

    task automatic test_pause_clear();
        int base;
        do_clear();
        for (int k = 0; k < 4; k++) push(0, mkw(0, k));
        base = wlog_n;
        q_en = 4'b0001;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (wlog_n - base !== 0 || q_rd_en !== 4'b0) begin errors++; $display("FAIL nocal: writes %0d rd_en %b want 0 0000", wlog_n - base, q_rd_en); end
        cal_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sw_enable = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (mem_w_n !== 1'b1 || mem_ad_wr !== '0 || mem_bwl_n !== 4'hf) begin errors++; $display("FAIL swoff_out: w_n %b a %0h bwl %0h want 1 0 f", mem_w_n, mem_ad_wr, mem_bwl_n); end
        checks++; if (q_cnt[0] !== '0 || q_rd_en !== 4'b0) begin errors++; $display("FAIL swoff_state: cnt %0d rd_en %b want 0 0000", q_cnt[0], q_rd_en); end
        sw_enable = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checks++; if (wlog_n - base !== 4) begin errors++; $display("FAIL swon_nwr: got %0d want 4", wlog_n - base); end
        for (int k = 0; k < 4 && base + k < wlog_n; k++) begin
            checks++;
            if (wlog_a[base+k] !== AW'(32'h10 + (k % 2)) || wlog_d[base+k] !== mkw(0, k)) begin
                errors++;
                $display("FAIL swon_wr%0d: got a=%0h d=%0h want a=%0h d=%0h", k, wlog_a[base+k], wlog_d[base+k], 32'h10 + (k % 2), mkw(0, k));
            end
        end
        checks++; if (q_cnt[0] !== 20'd2) begin errors++; $display("FAIL swon_cnt: got %0d want 2", q_cnt[0]); end
        cal_done = 1'b0; q_en = '0;
    endtask

    initial begin
        rst = 1'b1; sw_enable = 1'b1; cal_done = 1'b0; mem_wr_full = 1'b0;
        q_en = '0; flush = 4'hf;
        q_low = '0; q_high = '0;
        test_reset();
        test_single_queue();
        test_region_end();
        test_empty_region();
        test_round_robin();
        test_wr_full();
        test_pause_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
